// File: rtl/subleq_mem.sv
// Purpose : SUBLEQ byte memory with a streaming program loader, a shared tri-state
//           core data bus and a memory-mapped output port.
// Latency : core reads are combinational (zero cycles); writes land on the clk edge;
//           out_valid/out_data and cpu_en/ld_ready are registered (one cycle).
// Backpr. : loader bytes are accepted only while ld_ready=1 (LOAD); the core may use
//           the bus only while cpu_en=1 (RUN); the core side never back-pressures.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   cpu_en                   bus grant to the core (1 in RUN)
//   mem_we, mem_addr         core write strobe and byte address
//   mem_data                 shared little-endian 32-bit data bus (inout)
//   ld_valid/ld_ready        loader byte handshake; ld_byte data, ld_last final byte
//   ld_start                 request to return to LOAD (or restart the load pointer)
//   out_valid, out_data      one-cycle output-port pulse and byte-swapped held value
module subleq_mem #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] OUT_ADDR = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cpu_en,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    input  logic        ld_start,
    output logic        out_valid,
    output logic [31:0] out_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Program storage; deliberately not reset so a reset keeps loaded bytes.
    logic [7:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic                cpu_en_q, ld_ready_q;
    logic [ADDR_W-1:0]   ld_ptr_q, ld_ptr_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_data_q, out_data_d;

    logic                ld_acc;
    logic                cpu_wr;
    logic                is_out;
    logic                drive_en;
    logic [32:0]         lane_addr [4];
    logic [3:0]          lane_ok;
    logic [31:0]         rd_data;

    // rst is folded in so a byte presented while reset is held is never written.
    assign ld_acc = ld_valid & ld_ready_q & rst;
    assign cpu_wr = cpu_en_q & mem_we;
    assign is_out = (mem_addr == OUT_ADDR);

    // Per-lane byte addresses are computed with a 33rd bit so that a carry past
    // 2^32 counts as out of range rather than wrapping back to address 0.
    always_comb begin
        lane_ok = '0;
        rd_data = '0;
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = {1'b0, mem_addr} + 33'(k);
            lane_ok[k]   = (lane_addr[k][32:ADDR_W] == '0);
            rd_data[8*k +: 8] = lane_ok[k] ? mem[lane_addr[k][ADDR_W-1:0]] : 8'h00;
        end
        if (is_out) begin
            rd_data = '0;
        end
    end

    // Only a clean 0 on mem_we enables the driver; X/Z on the strobe keeps the bus released.
    assign drive_en = cpu_en_q && (mem_we === 1'b0);
    assign mem_data = drive_en ? rd_data : 32'bz;

    // Loader and core writes are mutually exclusive by state; lanes are unrolled so
    // each byte write has a fixed port.
    always_ff @(posedge clk) begin
        if (ld_acc) begin
            mem[ld_ptr_q] <= ld_byte;
        end
        if (cpu_wr && !is_out) begin
            if (lane_ok[0]) mem[lane_addr[0][ADDR_W-1:0]] <= mem_data[7:0];
            if (lane_ok[1]) mem[lane_addr[1][ADDR_W-1:0]] <= mem_data[15:8];
            if (lane_ok[2]) mem[lane_addr[2][ADDR_W-1:0]] <= mem_data[23:16];
            if (lane_ok[3]) mem[lane_addr[3][ADDR_W-1:0]] <= mem_data[31:24];
        end
    end

    always_comb begin
        state_d     = state_q;
        ld_ptr_d    = ld_ptr_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        case (state_q)
            S_LOAD: begin
                if (ld_acc) begin
                    // A full array ends the load exactly like an explicit last byte.
                    if (ld_last || (&ld_ptr_q)) begin
                        state_d  = S_RUN;
                        ld_ptr_d = '0;
                    end else begin
                        ld_ptr_d = ld_ptr_q + 1'b1;
                    end
                end
                if (ld_start) begin
                    ld_ptr_d = '0;
                end
            end
            S_RUN: begin
                if (cpu_wr && is_out) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {mem_data[7:0], mem_data[15:8],
                                   mem_data[23:16], mem_data[31:24]};
                end
                if (ld_start) begin
                    state_d  = S_LOAD;
                    ld_ptr_d = '0;
                end
            end
            default: begin
                state_d  = S_LOAD;
                ld_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_LOAD;
            cpu_en_q    <= 1'b0;
            ld_ready_q  <= 1'b1;
            ld_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cpu_en_q    <= (state_d == S_RUN);
            ld_ready_q  <= (state_d == S_LOAD);
            ld_ptr_q    <= ld_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign cpu_en    = cpu_en_q;
    assign ld_ready  = ld_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_subleq_mem.sv
// Purpose : self-checking bench for subleq_mem: vector table plus randomized traffic
//           against a byte-array reference model.
// Latency : reads checked combinationally, registered outputs checked after each edge.
// Backpr. : loader driven back-to-back; core traffic one operation per cycle.
module tb_subleq_mem;

    localparam int          ADDR_W   = 10;
    localparam int          DEPTH    = 1 << ADDR_W;
    localparam logic [31:0] OUT_ADDR = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        tb_drv = 1'b0;
    logic [31:0] tb_dat = '0;
    wire  [31:0] mem_data;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        ld_last = 1'b0;
    logic        ld_start = 1'b0;
    logic        cpu_en, ld_ready, out_valid;
    logic [31:0] out_data;

    assign mem_data = tb_drv ? tb_dat : 32'bz;

    subleq_mem #(.ADDR_W(ADDR_W), .OUT_ADDR(OUT_ADDR)) dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_byte(ld_byte),
        .ld_last(ld_last), .ld_start(ld_start), .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  model [DEPTH];
    logic [31:0] exp_out = '0;
    int          lp = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (a != OUT_ADDR) begin
            for (int k = 0; k < 4; k++) begin
                logic [32:0] ba;
                ba = {1'b0, a} + 33'(k);
                if (ba < 33'(DEPTH)) r[8*k +: 8] = model[ba[ADDR_W-1:0]];
            end
        end
        return r;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
        if (a == OUT_ADDR) begin
            exp_out = {d[7:0], d[15:8], d[23:16], d[31:24]};
        end else begin
            for (int k = 0; k < 4; k++) begin
                logic [32:0] ba;
                ba = {1'b0, a} + 33'(k);
                if (ba < 33'(DEPTH)) model[ba[ADDR_W-1:0]] = d[8*k +: 8];
            end
        end
    endtask

    // One loader byte per cycle; called #1 after an edge, returns #1 after the next.
    task automatic ld(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        @(posedge clk);
        #1;
        model[lp] = b;
        lp = (last || lp == DEPTH - 1) ? 0 : lp + 1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a);
        mem_addr = a;
        #1;
        chk(name, mem_data, ref_read(a));
    endtask

    task automatic hiz_chk(input string name);
        tb_drv = 1'b1;
        tb_dat = 32'hA5A5_5A5A;
        #1;
        chk({name, "_a"}, mem_data, 32'hA5A5_5A5A);
        tb_dat = 32'h5A5A_A5A5;
        #1;
        chk({name, "_b"}, mem_data, 32'h5A5A_A5A5);
        tb_drv = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] exp_rd;
        logic        exp_ov;
        logic [31:0] exp_od;
    } vec_t;

    localparam int NV = 17;
    vec_t tv [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_en", {31'b0, cpu_en}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        hiz_chk("rst_hiz");
        rst = 1'b1;
        #1;
        chk("rel_ld_ready", {31'b0, ld_ready}, 32'd1);
        chk("rel_cpu_en", {31'b0, cpu_en}, 32'd0);
        @(posedge clk);
        #1;

        // Full fill without ld_last; bytes 12..15 forced to zero for the later vectors.
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("full_cpu_en_before", {31'b0, cpu_en}, 32'd0);
            ld((i >= 12 && i < 16) ? 8'h00 : 8'($urandom), 1'b0);
        end
        chk("full_cpu_en_after", {31'b0, cpu_en}, 32'd1);
        chk("full_ld_ready", {31'b0, ld_ready}, 32'd0);
        rd_chk("full_rd_top", DEPTH - 4);
        rd_chk("full_rd_mid", 32'd500);

        // ld_valid is ignored in RUN.
        ld_valid = 1'b1;
        ld_byte  = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        ld_valid = 1'b0;
        rd_chk("run_ld_ignored", 32'd0);

        // ld_start returns to LOAD with the bus released.
        ld_start = 1'b1;
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        lp = 0;
        chk("start_cpu_en", {31'b0, cpu_en}, 32'd0);
        chk("start_ld_ready", {31'b0, ld_ready}, 32'd1);
        hiz_chk("start_hiz");

        // Reload 12 bytes 00..0B from address 0.
        for (int i = 0; i < 12; i++) begin
            if (i == 11) chk("ld12_cpu_en_before", {31'b0, cpu_en}, 32'd0);
            ld(8'(i), i == 11);
        end
        chk("ld12_cpu_en_after", {31'b0, cpu_en}, 32'd1);

        tv[0]  = '{1'b0, 32'd0,     32'h0,         32'h0302_0100, 1'b0, 32'h0};
        tv[1]  = '{1'b0, 32'd9,     32'h0,         32'h000B_0A09, 1'b0, 32'h0};
        tv[2]  = '{1'b1, 32'd4,     32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tv[3]  = '{1'b0, 32'd4,     32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0};
        tv[4]  = '{1'b0, 32'd6,     32'h0,         32'h0908_DEAD, 1'b0, 32'h0};
        tv[5]  = '{1'b1, OUT_ADDR,  32'h2A00_0000, 32'h2A00_0000, 1'b1, 32'h0000_002A};
        tv[6]  = '{1'b0, OUT_ADDR,  32'h0,         32'h0,         1'b0, 32'h0000_002A};
        tv[7]  = '{1'b0, 32'd4,     32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0000_002A};
        tv[8]  = '{1'b1, 32'd1020,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 32'h0000_002A};
        tv[9]  = '{1'b0, 32'd1022,  32'h0,         32'h0000_CAFE, 1'b0, 32'h0000_002A};
        tv[10] = '{1'b1, 32'd1023,  32'h1122_3344, 32'h1122_3344, 1'b0, 32'h0000_002A};
        tv[11] = '{1'b0, 32'd1020,  32'h0,         32'h44FE_F00D, 1'b0, 32'h0000_002A};
        tv[12] = '{1'b0, 32'hFFFF_FFFF, 32'h0,     32'h0,         1'b0, 32'h0000_002A};
        tv[13] = '{1'b1, 32'd1,     32'h5566_7788, 32'h5566_7788, 1'b0, 32'h0000_002A};
        tv[14] = '{1'b0, 32'd0,     32'h0,         32'h6677_8800, 1'b0, 32'h0000_002A};
        tv[15] = '{1'b0, 32'd3,     32'h0,         32'hADBE_5566, 1'b0, 32'h0000_002A};
        tv[16] = '{1'b0, 32'd1021,  32'h0,         32'h0044_FEF0, 1'b0, 32'h0000_002A};

        for (int i = 0; i < NV; i++) begin
            mem_we   = tv[i].we;
            mem_addr = tv[i].addr;
            tb_drv   = tv[i].we;
            tb_dat   = tv[i].wdat;
            #1;
            chk($sformatf("vec%0d_data", i), mem_data, tv[i].exp_rd);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ov", i), {31'b0, out_valid}, {31'b0, tv[i].exp_ov});
            chk($sformatf("vec%0d_od", i), out_data, tv[i].exp_od);
            if (tv[i].we) ref_write(tv[i].addr, tv[i].wdat);
        end
        mem_we = 1'b0;
        tb_drv = 1'b0;

        // Randomized core traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic        we;
            logic [31:0] a, d;
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'($urandom_range(0, DEPTH - 1));
                1: a = 32'(DEPTH - 4 + $urandom_range(0, 7));
                2: a = OUT_ADDR;
                3: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                4: a = $urandom;
                default: a = 32'($urandom_range(0, 15));
            endcase
            mem_we   = we;
            mem_addr = a;
            tb_drv   = we;
            tb_dat   = d;
            #1;
            chk($sformatf("rnd%0d_data", i), mem_data, we ? d : ref_read(a));
            @(posedge clk);
            #1;
            if (we) ref_write(a, d);
            chk($sformatf("rnd%0d_ov", i), {31'b0, out_valid}, {31'b0, we && a == OUT_ADDR});
            chk($sformatf("rnd%0d_od", i), out_data, exp_out);
        end

        // Reset asserted during a RUN write: the write must not land.
        mem_we   = 1'b1;
        mem_addr = 32'd8;
        tb_drv   = 1'b1;
        tb_dat   = 32'hFFFF_FFFF;
        #3;
        rst = 1'b0;
        #1;
        chk("rstrun_cpu_en", {31'b0, cpu_en}, 32'd0);
        @(posedge clk);
        #1;
        chk("rstrun_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rstrun_out_data", out_data, 32'd0);
        exp_out = '0;
        mem_we = 1'b0;
        tb_drv = 1'b0;
        lp = 0;
        rst = 1'b1;

        // ld_start inside LOAD restarts the pointer only.
        ld(8'hC0, 1'b0);
        ld(8'hC1, 1'b0);
        ld_start = 1'b1;
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        lp = 0;
        chk("ldstart_load_cpu_en", {31'b0, cpu_en}, 32'd0);
        chk("ldstart_load_ready", {31'b0, ld_ready}, 32'd1);

        // Five bytes, then asynchronous reset mid-load, then a short reload.
        for (int i = 0; i < 5; i++) ld(8'hA0 + 8'(i), 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("rstld_cpu_en", {31'b0, cpu_en}, 32'd0);
        lp = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) ld(8'hB0 + 8'(i), i == 2);
        chk("reload_cpu_en", {31'b0, cpu_en}, 32'd1);
        mem_addr = 32'd0;
        #1;
        chk("reload_rd0_const", mem_data, 32'hA3B2_B1B0);
        rd_chk("reload_rd4", 32'd4);
        rd_chk("rstrun_rd8", 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
